prvp_spi_slave_tx: RTL and testbench

- Transmit half of the SPI slave datapath: shifts a 32-bit word out MSB-first on sdo0 (single mode) or sdo3..sdo0 (quad mode).
- Words come from the slave controller/FIFO through a valid/ready port into a one-word holding buffer.
- A controller-supplied cycle target sets the shift length.
- Runs in the SPI serial-clock domain; the integrator drives clk from sclk (falling-edge launch) and rstnn from the deasserted-CS reset.

---
 rtl/prvp_spi_slave_tx.sv | 163 ++++++++++++++++
 tb/tb_prvp_spi_slave_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prvp_spi_slave_tx.sv
// prvp_spi_slave_tx: transmit half of the SPI slave datapath.
// Shifts a DATA_W-bit word out MSB-first on sdo0 (single) or sdo3..sdo0 (quad),
// fed by a one-word holding buffer behind a valid/ready port.
// Optional feature macro: PRVP_SPI_SLAVE_TX_UNDERRUN_EN (sticky underrun flag).
module prvp_spi_slave_tx #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              en_quad_in,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              counter_in_upd,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sdo0,
    output logic              sdo1,
    output logic              sdo2,
    output logic              sdo3,
    output logic              sdo_oe,
    output logic              tx_done,
    output logic              underrun
);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [DATA_W-1:0]   hb_q, hb_d;
    logic                hb_valid_q, hb_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tgt_q, tgt_d;
    logic                tx_done_q, tx_done_d;

    // Buffer is free whenever it holds no word; a word consumed this cycle
    // only frees the port on the following cycle.
    assign tx_ready = !hb_valid_q;
    assign tx_done  = tx_done_q;

    // State, shift register, holding buffer and counters.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            hb_q       <= '0;
            hb_valid_q <= 1'b0;
            cnt_q      <= '0;
            tgt_q      <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            hb_q       <= hb_d;
            hb_valid_q <= hb_valid_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Next-state logic: buffer accept, word start/restart, shifting and end of word.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        hb_d       = hb_q;
        hb_valid_d = hb_valid_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        tx_done_d  = 1'b0;

        // Accept only into an empty buffer, so this never collides with a
        // reload that consumes a full buffer.
        if (tx_valid && !hb_valid_q) begin
            hb_d       = tx_data;
            hb_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (counter_in_upd) begin
                    state_d = SHIFT;
                    tgt_d   = counter_in;
                    cnt_d   = '0;
                    if (hb_valid_q) begin
                        sr_d       = hb_q;
                        hb_valid_d = 1'b0;
                    end else begin
                        sr_d = '0;
                    end
                end
            end
            SHIFT: begin
                if (counter_in_upd) begin
                    // Restart abandons the current word without tx_done.
                    state_d = SHIFT;
                    tgt_d   = counter_in;
                    cnt_d   = '0;
                    if (hb_valid_q) begin
                        sr_d       = hb_q;
                        hb_valid_d = 1'b0;
                    end else begin
                        sr_d = '0;
                    end
                end else begin
                    if (en_quad_in) begin
                        sr_d = {sr_q[DATA_W-5:0], 4'b0000};
                    end else begin
                        sr_d = {sr_q[DATA_W-2:0], 1'b0};
                    end
                    if (cnt_q == tgt_q) begin
                        cnt_d     = '0;
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial outputs: driven from the shift register MSBs only while shifting.
    always_comb begin
        sdo_oe = 1'b0;
        sdo0   = 1'b0;
        sdo1   = 1'b0;
        sdo2   = 1'b0;
        sdo3   = 1'b0;
        if (state_q == SHIFT) begin
            sdo_oe = 1'b1;
            if (en_quad_in) begin
                {sdo3, sdo2, sdo1, sdo0} = sr_q[DATA_W-1 -: 4];
            end else begin
                sdo0 = sr_q[DATA_W-1];
            end
        end
    end

`ifdef PRVP_SPI_SLAVE_TX_UNDERRUN_EN
    logic underrun_q;
    logic underrun_set;

    // Any start (from IDLE or a restart) with an empty buffer is an underrun.
    assign underrun_set = counter_in_upd && !hb_valid_q;
    assign underrun     = underrun_q;

    // Sticky underrun flag, cleared only by reset.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            underrun_q <= 1'b0;
        end else if (underrun_set) begin
            underrun_q <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_prvp_spi_slave_tx.sv
// Self-checking bench for prvp_spi_slave_tx: table of single words plus
// hand-written back-to-back, restart and mid-word reset sequences.
module tb_prvp_spi_slave_tx;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

`ifdef PRVP_SPI_SLAVE_TX_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstnn;
    logic              en_quad_in;
    logic [CNT_W-1:0]  counter_in;
    logic              counter_in_upd;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sdo0, sdo1, sdo2, sdo3;
    logic              sdo_oe;
    logic              tx_done;
    logic              underrun;

    prvp_spi_slave_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rstnn          (rstnn),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .sdo0           (sdo0),
        .sdo1           (sdo1),
        .sdo2           (sdo2),
        .sdo3           (sdo3),
        .sdo_oe         (sdo_oe),
        .tx_done        (tx_done),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              quad;
        logic [CNT_W-1:0]  target;
        logic              preload;
    } vec_t;

    vec_t       tbl [5];
    int         vec_cnt  = 0;
    int         miss_cnt = 0;
    logic [4:0] exp_q [$];   // {sdo_oe, sdo3..sdo0} per SHIFT cycle

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pins for shift cycle k of a word, taken directly from the word's bits.
    function automatic logic [3:0] exp_nib(input logic [DATA_W-1:0] d, input logic q, input int k);
        logic [3:0] r;
        r = 4'b0000;
        if (q) begin
            if (k < DATA_W / 4) r = d[DATA_W-1-4*k -: 4];
        end else begin
            if (k < DATA_W) r = {3'b000, d[DATA_W-1-k]};
        end
        return r;
    endfunction

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic q, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({1'b1, exp_nib(d, q, k)});
    endtask

    task automatic drain(input string name, input int n);
        logic [4:0] e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL %s[%0d]: scoreboard empty, got sdo=0x%0h, expected an entry", name, i,
                         {sdo3, sdo2, sdo1, sdo0});
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s[%0d].sdo", name, i), {28'd0, sdo3, sdo2, sdo1, sdo0}, {28'd0, e[3:0]});
                check($sformatf("%s[%0d].oe", name, i), {31'd0, sdo_oe}, {31'd0, e[4]});
                check($sformatf("%s[%0d].done", name, i), {31'd0, tx_done}, 32'd0);
            end
            tick();
        end
    endtask

    task automatic start(input logic [CNT_W-1:0] t, input logic q);
        counter_in     = t;
        en_quad_in     = q;
        counter_in_upd = 1'b1;
        tick();
        counter_in_upd = 1'b0;
    endtask

    task automatic preload(input logic [DATA_W-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        tick();
        tick();
        rstnn = 1'b1;
        tick();
    endtask

    initial begin
        vec_t r;

        tbl[0] = '{data: 32'hA5C3_0F81, quad: 1'b0, target: 8'd31, preload: 1'b1};
        tbl[1] = '{data: 32'h1234_5678, quad: 1'b1, target: 8'd7,  preload: 1'b1};
        tbl[2] = '{data: 32'h0F0F_0001, quad: 1'b1, target: 8'd9,  preload: 1'b1};
        tbl[3] = '{data: 32'h8000_0001, quad: 1'b0, target: 8'd3,  preload: 1'b1};
        tbl[4] = '{data: 32'h0000_0000, quad: 1'b0, target: 8'd31, preload: 1'b0};

        rstnn          = 1'b0;
        en_quad_in     = 1'b0;
        counter_in     = '0;
        counter_in_upd = 1'b0;
        tx_data        = '0;
        tx_valid       = 1'b0;
        #1;
        check("rst.tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst.sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd0);
        check("rst.oe", {31'd0, sdo_oe}, 32'd0);
        check("rst.done", {31'd0, tx_done}, 32'd0);
        check("rst.underrun", {31'd0, underrun}, 32'd0);
        tick();
        tick();
        rstnn = 1'b1;
        tick();

        // Table-driven single words.
        for (int i = 0; i < 5; i++) begin
            r = tbl[i];
            if (r.preload) begin
                preload(r.data);
                check($sformatf("v%0d.full", i), {31'd0, tx_ready}, 32'd0);
            end else begin
                tx_data = 32'hFFFF_FFFF;   // present but not valid
            end
            start(r.target, r.quad);
            check($sformatf("v%0d.ready_after_load", i), {31'd0, tx_ready}, 32'd1);
            push_exp(r.data, r.quad, int'(r.target) + 1);
            drain($sformatf("v%0d", i), int'(r.target) + 1);
            check($sformatf("v%0d.done", i), {31'd0, tx_done}, 32'd1);
            check($sformatf("v%0d.oe_off", i), {31'd0, sdo_oe}, 32'd0);
            check($sformatf("v%0d.underrun", i), {31'd0, underrun}, r.preload ? 32'd0 : {31'd0, UR_EXP});
            tick();
            check($sformatf("v%0d.done_clr", i), {31'd0, tx_done}, 32'd0);
        end

        // Back-to-back: second word pushed during the first, restarted on tx_done.
        do_reset();
        preload(32'hDEAD_BEEF);
        start(8'd31, 1'b0);
        push_exp(32'hDEAD_BEEF, 1'b0, 32);
        tx_data  = 32'hCAFE_F00D;
        tx_valid = 1'b1;
        drain("b2b_a", 1);
        tx_valid = 1'b0;
        check("b2b.full", {31'd0, tx_ready}, 32'd0);
        drain("b2b_a", 31);
        check("b2b.done_a", {31'd0, tx_done}, 32'd1);
        start(8'd31, 1'b0);
        push_exp(32'hCAFE_F00D, 1'b0, 32);
        drain("b2b_b", 32);
        check("b2b.done_b", {31'd0, tx_done}, 32'd1);
        check("b2b.underrun", {31'd0, underrun}, 32'd0);
        tick();

        // Restart mid-word at shift cycle 10.
        preload(32'hF0F0_F0F0);
        start(8'd31, 1'b0);
        push_exp(32'hF0F0_F0F0, 1'b0, 11);
        tx_data  = 32'h9ABC_DEF1;
        tx_valid = 1'b1;
        drain("rs_a", 1);
        tx_valid = 1'b0;
        drain("rs_a", 9);
        counter_in     = 8'd31;
        counter_in_upd = 1'b1;
        drain("rs_a10", 1);
        counter_in_upd = 1'b0;
        push_exp(32'h9ABC_DEF1, 1'b0, 32);
        drain("rs_b", 32);
        check("rs.done", {31'd0, tx_done}, 32'd1);
        check("rs.underrun", {31'd0, underrun}, 32'd0);
        tick();

        // Asynchronous reset mid-word with a full holding buffer.
        preload(32'h1357_9BDF);
        start(8'd31, 1'b0);
        push_exp(32'h1357_9BDF, 1'b0, 5);
        tx_data  = 32'h2468_ACE0;
        tx_valid = 1'b1;
        drain("ar", 1);
        tx_valid = 1'b0;
        drain("ar", 4);
        check("ar.full", {31'd0, tx_ready}, 32'd0);
        rstnn = 1'b0;
        #1;
        check("ar.sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd0);
        check("ar.oe", {31'd0, sdo_oe}, 32'd0);
        check("ar.tx_ready", {31'd0, tx_ready}, 32'd1);
        check("ar.done", {31'd0, tx_done}, 32'd0);
        check("ar.underrun", {31'd0, underrun}, 32'd0);
        tick();
        rstnn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check($sformatf("ar.post[%0d].done", i), {31'd0, tx_done}, 32'd0);
            check($sformatf("ar.post[%0d].oe", i), {31'd0, sdo_oe}, 32'd0);
        end
        check("ar.post.tx_ready", {31'd0, tx_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
